display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Upstream feeder for the seven-segment decoder stage: holds the digits the user has keyed in and time-multiplexes them onto one shared 4-bit glyph-code bus, with a one-hot digit enable alongside. Also owns the timed "Err" message shown after a failed unlock attempt. Sits between the lock FSM/keypad path and the per-glyph seven-segment driver.

Parameters:
NUM_DIGITS, 4, number of display positions; also the entry buffer depth; range 3..8.
SCAN_DIV, 1000, clock cycles each digit stays selected; must be ≥ 2.
ERR_HOLD, 50000000, clock cycles the "Err" message is held; must be ≥ 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_valid  in  1  single-cycle strobe: key_code is valid.
key_code  in  4  glyph code: 0000-1001 digits, 1010 '*', 1011 '#'.
clear  in  1  single-cycle strobe: blank the entry buffer.
show_err  in  1  single-cycle strobe: start the "Err" message.
code_out  out  4  glyph code for the selected position, to the seven-segment driver.
digit_en  out  NUM_DIGITS  one-hot select; bit 0 is the rightmost position.
digit_count  out  $clog2(NUM_DIGITS+1)  number of digits currently entered.
err_active  out  1  high while the "Err" message is displayed.

Behaviour:
- Reset (async, rst_n=0):
  - Every buffer slot = 1110 (blank); digit_count=0; err_active=0.
  - Scan index=0; prescaler=0; digit_en=…0001; code_out=1110.
- Glyph codes: 0-9 digits; 1100 'E'; 1101 'r'; 1110 blank. 1010/1011 are never driven on code_out.
- Modes: ENTRY and ERR, encoded in a 1-bit state register. err_active is that register, driven directly.
- ENTRY mode, key_valid with a digit code:
  - If digit_count < NUM_DIGITS: buffer shifts left one slot, the new digit enters slot 0, digit_count increments.
  - At NUM_DIGITS the key is ignored (saturates); no wrap.
- ENTRY mode, key_valid with '*' (backspace):
  - If digit_count > 0: buffer shifts right, the top slot is filled with blank, digit_count decrements.
  - At 0 the key is ignored.
- ENTRY mode, key_valid with '#' or codes 1100-1111: ignored. Enter is the lock FSM's job.
- clear: every slot blank, digit_count=0, next cycle.
- show_err, from any mode:
  - Go to ERR; load the hold counter with ERR_HOLD-1; clear the buffer; digit_count=0.
  - show_err while already in ERR reloads the counter (restart).
- ERR mode display: slot2='E', slot1='r', slot0='r'; all higher slots blank.
- ERR mode inputs: key_valid is ignored. clear aborts ERR immediately and returns to ENTRY with a blank buffer.
- ERR timeout: when the hold counter reaches 0 with no show_err that cycle, return to ENTRY. Total time with err_active high is exactly ERR_HOLD cycles.
- Same-cycle priority: show_err > clear > key_valid.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and then wraps.
  - On wrap, the scan index advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - The scan runs free in both modes and is unaffected by clear/show_err.
- Outputs:
  - code_out and digit_en are registered.
  - Both update on the same edge, from the scan index and slot contents of the previous cycle.
  - The pair is therefore always mutually consistent.
  - A buffer change becomes visible on code_out one cycle after it is registered, and only while that slot is selected.
- Width rules: prescaler width $clog2(SCAN_DIV); hold counter width $clog2(ERR_HOLD); all comparisons unsigned.
- Reset asserted mid-operation returns everything to reset values asynchronously. The first scan step occurs SCAN_DIV cycles after rst_n deasserts.

Decomposition:
- Shared package/header holds the glyph-code constants: GLY_0..GLY_9, GLY_STAR=1010, GLY_HASH=1011, GLY_E=1100, GLY_R=1101, GLY_BLANK=1110.
  - The seven-segment driver uses the same constants.
- One sub-module: scan_timer, containing the prescaler plus scan-index counter. Outputs: scan_idx and step pulse; parameters NUM_DIGITS and SCAN_DIV.
- Buffer, mode FSM and output mux stay in the top module.

Test Plan:
- Reset then idle 4*SCAN_DIV cycles (SCAN_DIV=4): digit_en cycles 0001→0010→0100→1000→0001, each held 4 cycles; code_out=1110 throughout.
- Keys 1,2,3 → digit_count=3; slot0=3, slot1=2, slot2=1, slot3=blank, verified on code_out at each digit_en; then '*' → digit_count=2, slots 2,1.
- Keys 1,2,3,4,5 with NUM_DIGITS=4: fifth key ignored; slots 4,3,2,1; digit_count=4. '*' ×5 → digit_count=0, all blank, no underflow.
- Setup ERR_HOLD=10, show_err pulse: err_active high exactly 10 cycles; slots show r,r,E,blank; a key_valid=7 during ERR is ignored; after timeout the buffer is blank.
- In ERR, show_err at hold count 3 restarts: 10 more cycles. Then clear mid-ERR: err_active=0 next cycle.
- Same cycle: key_valid=5, clear=1, show_err=1 → ERR entered, buffer blank. Then assert rst_n=0 asynchronously mid-scan: outputs take reset values immediately, without a clock edge.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Glyph codes shared between the scan controller and the seven-segment driver,
// plus the display mode encoding.
package display_scan_ctrl_pkg;

    localparam logic [3:0] GLY_0     = 4'h0;
    localparam logic [3:0] GLY_1     = 4'h1;
    localparam logic [3:0] GLY_2     = 4'h2;
    localparam logic [3:0] GLY_3     = 4'h3;
    localparam logic [3:0] GLY_4     = 4'h4;
    localparam logic [3:0] GLY_5     = 4'h5;
    localparam logic [3:0] GLY_6     = 4'h6;
    localparam logic [3:0] GLY_7     = 4'h7;
    localparam logic [3:0] GLY_8     = 4'h8;
    localparam logic [3:0] GLY_9     = 4'h9;
    localparam logic [3:0] GLY_STAR  = 4'hA;
    localparam logic [3:0] GLY_HASH  = 4'hB;
    localparam logic [3:0] GLY_E     = 4'hC;
    localparam logic [3:0] GLY_R     = 4'hD;
    localparam logic [3:0] GLY_BLANK = 4'hE;

    typedef enum logic {
        MODE_ENTRY = 1'b0,
        MODE_ERR   = 1'b1
    } mode_e;

    // True for the ten numeric glyphs; everything from '*' upward is a control key.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= GLY_9;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Free-running digit scan: a prescaler that wraps every SCAN_DIV cycles and a
// position index that steps once per wrap, cycling 0..NUM_DIGITS-1.
module display_scan_ctrl_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    localparam int IW = $clog2(NUM_DIGITS),
    localparam int PW = $clog2(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] scan_idx,
    output logic          step
);

    logic [PW-1:0] presc;

    assign step = (presc == PW'(SCAN_DIV - 1));

    // Prescaler and scan index advance together; the index moves on prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (step) begin
            presc    <= '0;
            scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            presc    <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Entry buffer, ENTRY/ERR mode control and registered glyph/position output
// for the multiplexed seven-segment display.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  MODE_ENTRY | buffer shows keyed digits; digit and '*' keys are accepted
//  MODE_ERR   | "Err" shown for ERR_HOLD cycles; keys ignored, clear aborts
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ERR_HOLD   = 50000000,
    localparam int CW = $clog2(NUM_DIGITS + 1),
    localparam int IW = $clog2(NUM_DIGITS),
    localparam int HW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  clear,
    input  logic                  show_err,
    output logic [3:0]            code_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [CW-1:0]         digit_count,
    output logic                  err_active
);

    mode_e         state, state_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          buf_clr;
    logic          key_push, key_pop;
    logic [3:0]    slots [NUM_DIGITS];
    logic [IW-1:0] scan_idx;
    logic          scan_step;
    logic [3:0]    glyph_nxt;

    display_scan_ctrl_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_idx (scan_idx),
        .step     (scan_step)
    );

    // The mode register itself is the error indicator.
    assign err_active = state;

    // Mode and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_ENTRY;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    // Next mode: show_err beats clear, clear beats the hold timeout.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        buf_clr   = 1'b0;
        if (show_err) begin
            state_nxt = MODE_ERR;
            hold_nxt  = HW'(ERR_HOLD - 1);
            buf_clr   = 1'b1;
        end else if (clear) begin
            state_nxt = MODE_ENTRY;
            buf_clr   = 1'b1;
        end else if (state == MODE_ERR) begin
            if (hold == '0) begin
                state_nxt = MODE_ENTRY;
            end else begin
                hold_nxt = hold - 1'b1;
            end
        end
    end

    // Keys only act in ENTRY mode and only when no higher-priority strobe is present.
    always_comb begin
        key_push = 1'b0;
        key_pop  = 1'b0;
        if (!show_err && !clear && state == MODE_ENTRY && key_valid) begin
            key_push = is_digit(key_code) && (digit_count < CW'(NUM_DIGITS));
            key_pop  = (key_code == GLY_STAR) && (digit_count != '0);
        end
    end

    // Entry buffer: new digits enter at slot 0, backspace shifts back toward slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= GLY_BLANK;
            digit_count <= '0;
        end else if (buf_clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= GLY_BLANK;
            digit_count <= '0;
        end else if (key_push) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) slots[i] <= slots[i-1];
            slots[0]    <= key_code;
            digit_count <= digit_count + 1'b1;
        end else if (key_pop) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) slots[i] <= slots[i+1];
            slots[NUM_DIGITS-1] <= GLY_BLANK;
            digit_count <= digit_count - 1'b1;
        end
    end

    // Glyph for the currently selected position; ERR mode overrides the buffer.
    always_comb begin
        glyph_nxt = GLY_BLANK;
        if (state == MODE_ERR) begin
            if (scan_idx == IW'(0) || scan_idx == IW'(1)) begin
                glyph_nxt = GLY_R;
            end else if (scan_idx == IW'(2)) begin
                glyph_nxt = GLY_E;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (scan_idx == IW'(i)) glyph_nxt = slots[i];
            end
        end
    end

    // Code and enable registered on the same edge so the pair never disagrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out <= GLY_BLANK;
            digit_en <= NUM_DIGITS'(1);
        end else begin
            code_out <= glyph_nxt;
            digit_en <= NUM_DIGITS'(1) << scan_idx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random key traffic,
// all compared against a queue-based behavioural model of the display.
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int EH = 10;
    localparam int CW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          clear;
    logic          show_err;
    logic [3:0]    code_out;
    logic [ND-1:0] digit_en;
    logic [CW-1:0] digit_count;
    logic          err_active;

    int checks = 0;
    int passed = 0;

    // model state
    int m_n;
    int m_digits[$];
    bit m_err;
    int m_hold;
    int exp_code;
    int exp_en;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .ERR_HOLD   (EH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .clear       (clear),
        .show_err    (show_err),
        .code_out    (code_out),
        .digit_en    (digit_en),
        .digit_count (digit_count),
        .err_active  (err_active)
    );

    function automatic int model_glyph(int pos);
        if (m_err) begin
            if (pos <= 1) return 13;
            if (pos == 2) return 12;
            return 14;
        end
        if (pos < m_digits.size()) return m_digits[pos];
        return 14;
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_digits.delete();
        m_err = 0;
        m_hold = 0;
    endtask

    // One clock: capture what the display should show after this edge, apply
    // the driven strobes to the model, then let the edge happen.
    task automatic step();
        int pos;
        pos = (m_n / SD) % ND;
        exp_code = model_glyph(pos);
        exp_en = 1 << pos;
        if (show_err) begin
            m_err = 1;
            m_hold = EH - 1;
            m_digits.delete();
        end else if (clear) begin
            m_err = 0;
            m_digits.delete();
        end else if (m_err) begin
            if (m_hold == 0) m_err = 0;
            else m_hold--;
        end else if (key_valid) begin
            if (key_code <= 9 && m_digits.size() < ND) m_digits.push_front(int'(key_code));
            else if (key_code == 10 && m_digits.size() > 0) void'(m_digits.pop_front());
        end
        m_n++;
        @(posedge clk);
        #1;
        key_valid = 0;
        clear = 0;
        show_err = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        key_valid = 0;
        key_code = 0;
        clear = 0;
        show_err = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (code_out !== 4'hE) $display("FAIL reset_code: got %h expected e", code_out);
        else passed++;
        checks++;
        if (digit_en !== 4'b0001) $display("FAIL reset_en: got %b expected 0001", digit_en);
        else passed++;
        checks++;
        if (digit_count !== 0) $display("FAIL reset_count: got %0d expected 0", digit_count);
        else passed++;
        checks++;
        if (err_active !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_active);
        else passed++;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_scan();
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            checks++;
            if (digit_en !== exp_en[ND-1:0]) $display("FAIL scan_en: cycle %0d got %b expected %b", i, digit_en, exp_en[ND-1:0]);
            else passed++;
            checks++;
            if (code_out !== 4'hE) $display("FAIL scan_code: cycle %0d got %h expected e", i, code_out);
            else passed++;
        end
    endtask

    task automatic test_keys();
        int keys[3] = '{1, 2, 3};
        foreach (keys[k]) begin
            key_valid = 1;
            key_code = 4'(keys[k]);
            step();
        end
        checks++;
        if (digit_count !== 3) $display("FAIL keys_count: got %0d expected 3", digit_count);
        else passed++;
        for (int i = 0; i < ND * SD; i++) begin
            step();
            checks++;
            if (code_out !== exp_code[3:0] || digit_en !== exp_en[ND-1:0])
                $display("FAIL keys_disp: got %h/%b expected %h/%b", code_out, digit_en, exp_code[3:0], exp_en[ND-1:0]);
            else passed++;
            if (digit_en == 4'b0001) begin
                checks++;
                if (code_out !== 4'h3) $display("FAIL keys_slot0: got %h expected 3", code_out);
                else passed++;
            end
            if (digit_en == 4'b1000) begin
                checks++;
                if (code_out !== 4'hE) $display("FAIL keys_slot3: got %h expected e", code_out);
                else passed++;
            end
        end
        key_valid = 1;
        key_code = 4'hA;
        step();
        checks++;
        if (digit_count !== 2) $display("FAIL keys_bksp: got %0d expected 2", digit_count);
        else passed++;
        for (int i = 0; i < ND * SD; i++) begin
            step();
            checks++;
            if (code_out !== exp_code[3:0] || digit_en !== exp_en[ND-1:0])
                $display("FAIL bksp_disp: got %h/%b expected %h/%b", code_out, digit_en, exp_code[3:0], exp_en[ND-1:0]);
            else passed++;
        end
    endtask

    task automatic test_saturate();
        clear = 1;
        step();
        for (int k = 1; k <= 5; k++) begin
            key_valid = 1;
            key_code = 4'(k);
            step();
        end
        checks++;
        if (digit_count !== 4) $display("FAIL sat_count: got %0d expected 4", digit_count);
        else passed++;
        for (int i = 0; i < ND * SD; i++) begin
            step();
            checks++;
            if (code_out !== exp_code[3:0]) $display("FAIL sat_disp: got %h expected %h", code_out, exp_code[3:0]);
            else passed++;
            if (digit_en == 4'b1000) begin
                checks++;
                if (code_out !== 4'h1) $display("FAIL sat_slot3: got %h expected 1", code_out);
                else passed++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            key_valid = 1;
            key_code = 4'hA;
            step();
        end
        checks++;
        if (digit_count !== 0) $display("FAIL underflow_count: got %0d expected 0", digit_count);
        else passed++;
        for (int i = 0; i < ND * SD; i++) begin
            step();
            checks++;
            if (code_out !== 4'hE) $display("FAIL underflow_disp: got %h expected e", code_out);
            else passed++;
        end
    endtask

    task automatic test_err();
        int hi;
        key_valid = 1;
        key_code = 4'h9;
        step();
        show_err = 1;
        step();
        hi = 0;
        if (err_active === 1'b1) hi++;
        for (int i = 0; i < EH + 6; i++) begin
            if (i == 3) begin
                key_valid = 1;
                key_code = 4'h7;
            end
            step();
            if (err_active === 1'b1) hi++;
            checks++;
            if (code_out !== exp_code[3:0] || err_active !== m_err)
                $display("FAIL err_disp: got %h/%b expected %h/%b", code_out, err_active, exp_code[3:0], m_err);
            else passed++;
        end
        checks++;
        if (hi != EH) $display("FAIL err_len: got %0d expected %0d", hi, EH);
        else passed++;
        checks++;
        if (digit_count !== 0) $display("FAIL err_after_count: got %0d expected 0", digit_count);
        else passed++;
    endtask

    task automatic test_restart();
        int hi;
        show_err = 1;
        step();
        for (int i = 0; i < EH && m_hold != 3; i++) step();
        checks++;
        if (err_active !== 1'b1) $display("FAIL restart_pre: got %b expected 1", err_active);
        else passed++;
        show_err = 1;
        step();
        hi = (err_active === 1'b1) ? 1 : 0;
        for (int i = 0; i < EH + 4; i++) begin
            step();
            if (err_active === 1'b1) hi++;
        end
        checks++;
        if (hi != EH) $display("FAIL restart_len: got %0d expected %0d", hi, EH);
        else passed++;
        show_err = 1;
        step();
        step();
        step();
        clear = 1;
        step();
        checks++;
        if (err_active !== 1'b0) $display("FAIL clear_abort: got %b expected 0", err_active);
        else passed++;
    endtask

    task automatic test_priority();
        key_valid = 1;
        key_code = 4'h5;
        clear = 1;
        show_err = 1;
        step();
        checks++;
        if (err_active !== 1'b1) $display("FAIL prio_err: got %b expected 1", err_active);
        else passed++;
        checks++;
        if (digit_count !== 0) $display("FAIL prio_count: got %0d expected 0", digit_count);
        else passed++;
        clear = 1;
        step();
        key_valid = 1;
        key_code = 4'h4;
        clear = 1;
        step();
        checks++;
        if (digit_count !== 0 || err_active !== 1'b0) $display("FAIL prio_clear: got %0d/%b expected 0/0", digit_count, err_active);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            key_valid = ($urandom_range(0, 2) == 0);
            key_code = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 40) == 0);
            show_err = ($urandom_range(0, 60) == 0);
            step();
            checks++;
            if (code_out !== exp_code[3:0] || digit_en !== exp_en[ND-1:0] ||
                digit_count !== m_digits.size() || err_active !== m_err)
                $display("FAIL random: cycle %0d got %h/%b/%0d/%b expected %h/%b/%0d/%b", i,
                         code_out, digit_en, digit_count, err_active,
                         exp_code[3:0], exp_en[ND-1:0], m_digits.size(), m_err);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        key_valid = 1;
        key_code = 4'h8;
        step();
        step();
        step();
        #3;
        rst_n = 0;
        #1;
        checks++;
        if (code_out !== 4'hE || digit_en !== 4'b0001 || digit_count !== 0 || err_active !== 1'b0)
            $display("FAIL async_reset: got %h/%b/%0d/%b expected e/0001/0/0", code_out, digit_en, digit_count, err_active);
        else passed++;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 2 * SD; i++) begin
            step();
            checks++;
            if (code_out !== exp_code[3:0] || digit_en !== exp_en[ND-1:0])
                $display("FAIL post_reset: got %h/%b expected %h/%b", code_out, digit_en, exp_code[3:0], exp_en[ND-1:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_keys();
        test_saturate();
        test_err();
        test_restart();
        test_priority();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
